// File: rtl/qpsk_frame_sync.sv
// qpsk_frame_sync: frame synchroniser for the QPSK demodulator bit stream.
// Hunts for SYNC_WORD, confirms it over CONFIRM_CNT frames, then flywheels
// through up to MISS_MAX-1 bad headers while delivering payload bytes.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   ser_bit       demodulated serial bit, valid when bit_valid = 1
//   bit_valid     one-clock bit strobe
//   resync        synchronous request to drop lock and restart the hunt
//   byte_data     payload byte, first received bit in bit 7
//   byte_valid    one-clock pulse qualifying byte_data
//   frame_start   pulse on each accepted header while locked
//   frame_end     pulse with the last byte of a frame
//   locked        high while in LOCK
//   sync_state    0 = SEARCH, 1 = VERIFY, 2 = LOCK
module qpsk_frame_sync #(
    parameter logic [15:0] SYNC_WORD     = 16'hEB90,
    parameter int unsigned PAYLOAD_BYTES = 8,
    parameter int unsigned CONFIRM_CNT   = 2,
    parameter int unsigned MISS_MAX      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ser_bit,
    input  logic       bit_valid,
    input  logic       resync,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_start,
    output logic       frame_end,
    output logic       locked,
    output logic [1:0] sync_state
);

    localparam int unsigned PAY_BITS   = 8 * PAYLOAD_BYTES;
    localparam int unsigned FRAME_BITS = PAY_BITS + 16;
    localparam int unsigned POS_W      = $clog2(FRAME_BITS);
    localparam int unsigned CNT_W      = 3;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCK   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    // Only the 15 most recent bits are kept; the 16th comes from ser_bit.
    logic [14:0]      sreg_q, sreg_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    // Seven bits suffice: the eighth bit of a byte goes straight to byte_data.
    logic [6:0]       byte_sr_q, byte_sr_d;
    logic [7:0]       byte_data_q, byte_data_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_end_q, frame_end_d;
    logic             locked_q, locked_d;

    logic [15:0]      cand;
    logic             match;
    logic             hdr_pos;
    logic             pay_pos;
    logic [7:0]       nxt_byte;
    logic [POS_W-1:0] pos_inc;

    // Candidate window and frame position decode
    assign cand     = {sreg_q, ser_bit};
    assign match    = (cand == SYNC_WORD);
    assign hdr_pos  = (pos_q == POS_W'(FRAME_BITS - 1));
    assign pay_pos  = (pos_q < POS_W'(PAY_BITS));
    assign nxt_byte = {byte_sr_q, ser_bit};
    assign pos_inc  = hdr_pos ? '0 : pos_q + POS_W'(1);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_SEARCH;
            sreg_q        <= '0;
            pos_q         <= '0;
            hit_q         <= '0;
            miss_q        <= '0;
            byte_sr_q     <= '0;
            byte_data_q   <= '0;
            byte_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            sreg_q        <= sreg_d;
            pos_q         <= pos_d;
            hit_q         <= hit_d;
            miss_q        <= miss_d;
            byte_sr_q     <= byte_sr_d;
            byte_data_q   <= byte_data_d;
            byte_valid_q  <= byte_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            locked_q      <= locked_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        sreg_d        = sreg_q;
        pos_d         = pos_q;
        hit_d         = hit_q;
        miss_d        = miss_q;
        byte_sr_d     = byte_sr_q;
        byte_data_d   = byte_data_q;
        byte_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;

        // The bit history keeps shifting even on a resync cycle.
        if (bit_valid) begin
            sreg_d = cand[14:0];
        end

        if (resync) begin
            state_d   = ST_SEARCH;
            pos_d     = '0;
            hit_d     = '0;
            miss_d    = '0;
            byte_sr_d = '0;
        end else if (bit_valid) begin
            case (state_q)
                ST_SEARCH: begin
                    if (match) begin
                        pos_d = '0;
                        hit_d = CNT_W'(1);
                        if (CONFIRM_CNT == 1) begin
                            state_d       = ST_LOCK;
                            miss_d        = '0;
                            frame_start_d = 1'b1;
                        end else begin
                            state_d = ST_VERIFY;
                        end
                    end
                end
                ST_VERIFY: begin
                    pos_d = pos_inc;
                    if (hdr_pos) begin
                        if (match) begin
                            hit_d = hit_q + CNT_W'(1);
                            if (hit_q + CNT_W'(1) == CNT_W'(CONFIRM_CNT)) begin
                                state_d       = ST_LOCK;
                                miss_d        = '0;
                                frame_start_d = 1'b1;
                            end
                        end else begin
                            state_d = ST_SEARCH;
                            hit_d   = '0;
                        end
                    end
                end
                ST_LOCK: begin
                    pos_d = pos_inc;
                    if (pay_pos) begin
                        byte_sr_d = nxt_byte[6:0];
                        if (pos_q[2:0] == 3'd7) begin
                            byte_data_d  = nxt_byte;
                            byte_valid_d = 1'b1;
                            frame_end_d  = (pos_q == POS_W'(PAY_BITS - 1));
                        end
                    end
                    if (hdr_pos) begin
                        if (match) begin
                            miss_d        = '0;
                            frame_start_d = 1'b1;
                        end else if (miss_q + CNT_W'(1) == CNT_W'(MISS_MAX)) begin
                            state_d = ST_SEARCH;
                            miss_d  = '0;
                            hit_d   = '0;
                        end else begin
                            miss_d = miss_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end

        locked_d = (state_d == ST_LOCK);
    end

    assign byte_data   = byte_data_q;
    assign byte_valid  = byte_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign locked      = locked_q;
    assign sync_state  = state_q;

endmodule

// File: tb/tb_qpsk_frame_sync.sv
// tb_qpsk_frame_sync: table-driven frame sequences, hand-written resync and
// reset corner cases, and randomized frames checked against a bit-level
// behavioural model of the synchroniser rules.
module tb_qpsk_frame_sync;

    localparam int P     = 4;
    localparam int F     = 16 + 8 * P;
    localparam int CONF  = 2;
    localparam int MISSM = 2;
    localparam logic [15:0] SYNC = 16'hEB90;

    logic       clk;
    logic       rst_n;
    logic       ser_bit;
    logic       bit_valid;
    logic       resync;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       frame_start;
    logic       frame_end;
    logic       locked;
    logic [1:0] sync_state;

    qpsk_frame_sync #(
        .SYNC_WORD    (SYNC),
        .PAYLOAD_BYTES(P),
        .CONFIRM_CNT  (CONF),
        .MISS_MAX     (MISSM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ser_bit    (ser_bit),
        .bit_valid  (bit_valid),
        .resync     (resync),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .locked     (locked),
        .sync_state (sync_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int fs_cnt;
    int bv_cnt;
    logic [7:0] got_q[$];

    // Behavioural model state
    int          m_state;
    int          m_pos;
    int          m_hit;
    int          m_miss;
    logic [15:0] m_hist;
    bit          m_pay[$];
    logic        e_bv, e_fs, e_fe;
    logic [7:0]  e_bd;

    typedef struct {
        logic [15:0] hdr;
        logic [31:0] pay;
        int          exp_state;
        int          exp_fs;
        int          exp_nbytes;
    } row_t;
    row_t rows[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_pos = 0; m_hit = 0; m_miss = 0; m_hist = '0;
        m_pay.delete();
    endtask

    // One bit of the stream, straight from the frame rules; sets e_* for the
    // outputs expected one clock after the strobe.
    task automatic model_step(input logic b, input logic rs);
        logic [15:0] w;
        int n;
        w = {m_hist[14:0], b};
        m_hist = w;
        e_bv = 1'b0; e_fs = 1'b0; e_fe = 1'b0;
        if (rs) begin
            m_state = 0; m_pos = 0; m_hit = 0; m_miss = 0;
            m_pay.delete();
            return;
        end
        case (m_state)
            0: if (w == SYNC) begin
                m_pos = 0;
                m_hit = 1;
                if (CONF == 1) begin m_state = 2; m_miss = 0; e_fs = 1'b1; end
                else m_state = 1;
            end
            1: begin
                if (m_pos == F - 1) begin
                    if (w == SYNC) begin
                        m_hit++;
                        if (m_hit == CONF) begin m_state = 2; m_miss = 0; e_fs = 1'b1; end
                    end else begin
                        m_state = 0; m_hit = 0;
                    end
                end
                m_pos = (m_pos + 1) % F;
            end
            default: begin
                if (m_pos < 8 * P) begin
                    m_pay.push_back(b);
                    n = m_pay.size();
                    if (n % 8 == 0) begin
                        e_bv = 1'b1;
                        e_bd = '0;
                        for (int k = 0; k < 8; k++) e_bd = {e_bd[6:0], m_pay[n - 8 + k]};
                        e_fe = (n == 8 * P);
                    end
                end
                if (m_pos == F - 1) begin
                    m_pay.delete();
                    if (w == SYNC) begin
                        m_miss = 0; e_fs = 1'b1;
                    end else begin
                        m_miss++;
                        if (m_miss == MISSM) begin m_state = 0; m_miss = 0; m_hit = 0; end
                    end
                end
                m_pos = (m_pos + 1) % F;
            end
        endcase
    endtask

    // One strobe every 11 clocks; outputs checked one clock after the strobe
    // and again a clock later to confirm the pulses cleared.
    task automatic send_bit(input logic b, input logic rs);
        @(negedge clk);
        ser_bit = b; bit_valid = 1'b1; resync = rs;
        model_step(b, rs);
        @(posedge clk); #1;
        bit_valid = 1'b0; resync = 1'b0;
        check("byte_valid", int'(byte_valid), int'(e_bv));
        if (e_bv) check("byte_data", int'(byte_data), int'(e_bd));
        check("frame_end", int'(frame_end), int'(e_fe));
        check("frame_start", int'(frame_start), int'(e_fs));
        check("sync_state", int'(sync_state), m_state);
        check("locked", int'(locked), int'(m_state == 2));
        fs_cnt += int'(frame_start);
        bv_cnt += int'(byte_valid);
        if (byte_valid) got_q.push_back(byte_data);
        @(posedge clk); #1;
        check("pulses_clear", int'({byte_valid, frame_start, frame_end}), 0);
        check("state_hold", int'(sync_state), m_state);
        repeat (9) @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int n);
        for (int k = n - 1; k >= 0; k--) send_bit(w[k], 1'b0);
    endtask

    initial begin
        logic [15:0] h;
        logic        b;
        logic [31:0] p;
        logic [15:0] hdr;

        rows[0] = '{16'hEB90, 32'h12345678, 1, 0, 0};
        rows[1] = '{16'hEB90, 32'hA55AFF00, 2, 1, 4};
        rows[2] = '{16'hEB91, 32'h11223344, 2, 0, 4};
        rows[3] = '{16'hEB90, 32'h55667788, 2, 1, 4};
        rows[4] = '{16'hEB91, 32'h9ABCDEF0, 2, 0, 4};
        rows[5] = '{16'hEB91, 32'h00000000, 0, 0, 0};
        rows[6] = '{16'hEB90, 32'hEB90EB90, 1, 0, 0};
        rows[7] = '{16'h1234, 32'h00000000, 0, 0, 0};

        rst_n = 1'b0; ser_bit = 1'b0; bit_valid = 1'b0; resync = 1'b0;
        model_reset();
        repeat (3) @(posedge clk); #1;
        check("rst_byte_data", int'(byte_data), 0);
        check("rst_pulses", int'({byte_valid, frame_start, frame_end}), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_state", int'(sync_state), 0);
        @(negedge clk); rst_n = 1'b1;

        // Random preamble that never forms the sync word
        fs_cnt = 0; bv_cnt = 0;
        h = '0;
        for (int i = 0; i < 64; i++) begin
            b = 1'($urandom);
            if ({h[14:0], b} == SYNC) b = ~b;
            h = {h[14:0], b};
            send_bit(b, 1'b0);
        end
        check("pre_state", int'(sync_state), 0);
        check("pre_fs", fs_cnt, 0);
        check("pre_bytes", bv_cnt, 0);

        // Table of header + payload units
        for (int i = 0; i < 8; i++) begin
            fs_cnt = 0; bv_cnt = 0; got_q.delete();
            send_word(32'(rows[i].hdr), 16);
            check("row_hdr_state", int'(sync_state), rows[i].exp_state);
            send_word(rows[i].pay, 32);
            check("row_end_state", int'(sync_state), rows[i].exp_state);
            check("row_fs", fs_cnt, rows[i].exp_fs);
            check("row_bytes", bv_cnt, rows[i].exp_nbytes);
            if (got_q.size() == rows[i].exp_nbytes && rows[i].exp_nbytes == 4) begin
                p = rows[i].pay;
                for (int k = 0; k < 4; k++)
                    check("row_byte_val", int'(got_q[k]), int'(8'(p >> (24 - 8 * k))));
            end
        end

        // Resync mid-byte while locked
        send_word(32'(SYNC), 16);
        send_word($urandom, 32);
        send_word(32'(SYNC), 16);
        check("relock", int'(locked), 1);
        bv_cnt = 0;
        send_word(32'h5, 3);
        send_bit(1'b1, 1'b1);
        check("resync_state", int'(sync_state), 0);
        check("resync_locked", int'(locked), 0);
        send_word(32'h0, 4);
        check("resync_no_bytes", bv_cnt, 0);

        // Asynchronous reset mid-frame, just after a byte
        send_word(32'(SYNC), 16);
        send_word($urandom, 32);
        send_word(32'(SYNC), 16);
        send_word(32'hC3, 8);
        send_word(32'h1, 3);
        check("pre_reset_locked", int'(locked), 1);
        check("pre_reset_data", int'(byte_data), 8'hC3);
        #3 rst_n = 1'b0;
        #1;
        check("arst_byte_data", int'(byte_data), 0);
        check("arst_pulses", int'({byte_valid, frame_start, frame_end}), 0);
        check("arst_locked", int'(locked), 0);
        check("arst_state", int'(sync_state), 0);
        model_reset();
        @(negedge clk); rst_n = 1'b1;

        // Randomized frames with occasional bad headers and resyncs
        for (int f = 0; f < 16; f++) begin
            hdr = ($urandom_range(0, 3) != 0) ? SYNC : 16'($urandom);
            p = $urandom;
            for (int k = 15; k >= 0; k--) send_bit(hdr[k], 1'($urandom_range(0, 299) == 0));
            for (int k = 31; k >= 0; k--) send_bit(p[k], 1'($urandom_range(0, 299) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qpsk_frame_sync.md
Name: qpsk_frame_sync

Overview:
- Frame-synchronisation controller placed after the IQ-combining stage of the QPSK demodulator.
- Consumes the serial demodulated bit stream and its one-clock bit strobe.
- Hunts for a fixed sync word and confirms it over several frames before declaring lock.
- While locked, flywheels through missed headers and delivers payload bytes with frame markers to the downstream sink.

Parameters:
SYNC_WORD  16'hEB90  header pattern, transmitted MSB first
PAYLOAD_BYTES  8  payload bytes per frame (1..255); frame length F = 16 + 8*PAYLOAD_BYTES bits
CONFIRM_CNT  2  consecutive header hits needed to enter LOCK, including the first (1..7)
MISS_MAX  2  consecutive header misses in LOCK that force SEARCH (1..7)

Ports:
clk  in  1  system clock (500 kHz symbol clock domain)
rst_n  in  1  asynchronous active-low reset
ser_bit  in  1  demodulated serial bit
bit_valid  in  1  one-clock strobe; ser_bit is valid only in this cycle
resync  in  1  synchronous request to drop lock and restart the search
byte_data  out  8  assembled payload byte, first received bit in bit 7
byte_valid  out  1  one-clock pulse; byte_data is valid in this cycle
frame_start  out  1  one-clock pulse on each accepted header while locked
frame_end  out  1  one-clock pulse coincident with the last byte_valid of a frame
locked  out  1  high while state = LOCK
sync_state  out  2  0 = SEARCH, 1 = VERIFY, 2 = LOCK

Behaviour:
- Reset (async, rst_n low):
  - state SEARCH; all outputs 0.
  - Shift register, position counter, hit and miss counters cleared.
- Processing happens only in cycles with bit_valid = 1; otherwise all state holds.
- Single-cycle pulse outputs return to 0 in the next cycle.
- Shift register: sreg <= {sreg[14:0], ser_bit}. Define cand = {sreg[14:0], ser_bit} and match = (cand == SYNC_WORD).
- Position counter pos:
  - Range 0..F-1.
  - Payload bits occupy pos 0..8P-1; header bits occupy pos 8P..F-1.
  - The header check occurs at pos = F-1. pos then wraps to 0.
- SEARCH:
  - On match: go to VERIFY with pos = 0 and hit = 1.
  - If CONFIRM_CNT = 1, go directly to LOCK instead, with frame_start pulsed.
- VERIFY:
  - pos increments each bit; no byte output.
  - At pos = F-1 with match: hit++. When hit reaches CONFIRM_CNT, go to LOCK, pulse frame_start, set miss = 0.
  - At pos = F-1 without match: go to SEARCH and clear hit.
- LOCK:
  - Payload bits shift into a byte register MSB first.
  - On the bit_valid carrying the 8th bit of a byte, byte_data and byte_valid are registered. They appear the cycle after that strobe (latency 1 clock).
  - frame_end accompanies the byte at pos = 8P-1.
  - Header check at pos = F-1:
    - match: miss = 0, pulse frame_start (same cycle as the check result, one clock after the strobe).
    - no match: miss++. If miss reaches MISS_MAX, go to SEARCH (locked drops next cycle) with no frame_start. Otherwise stay in LOCK (flywheel) with no frame_start; the next frame's payload is still output.
- resync:
  - Forces SEARCH next cycle; clears pos, hit, miss and the byte register.
  - Takes priority over any simultaneous bit_valid transition.
  - A bit arriving in the same cycle still shifts into sreg.
  - No byte_valid is emitted for a partial byte.
- Header bits in LOCK are never emitted as payload.
- A header-pattern occurrence inside the payload while in VERIFY or LOCK is ignored; only pos = F-1 is checked.
- sync_state and locked are registered and change the cycle after the deciding strobe.

Test Plan:
All scenarios use PAYLOAD_BYTES = 4 (F = 48), CONFIRM_CNT = 2, MISS_MAX = 2, and one bit_valid every 11 clocks.

1. Reset, then random bits containing no EB90 → sync_state stays 0; byte_valid, locked and frame_start all remain 0.
2. Preamble, then EB90 + payload 12 34 56 78, then EB90 + payload A5 5A FF 00 →
   - sync_state goes 1 after the first header and 2 after the second.
   - frame_start pulses once.
   - The next frame's bytes come out A5 5A FF 00, each one clock after its 8th strobe, with frame_end on 00.
3. Locked, one corrupted header (EB91) followed by a good one → locked stays 1; payload bytes of both frames are delivered; frame_start is absent for the corrupted frame; miss resets to 0.
4. Locked, two consecutive corrupted headers → sync_state returns to 0 the cycle after the second check; no further byte_valid occurs.
5. VERIFY entered, then a wrong second header → back to SEARCH; no byte_valid during the whole sequence. Also check that EB90 embedded inside a payload while in VERIFY causes no early transition.
6. resync asserted mid-byte while in LOCK, in the same cycle as a bit_valid → no byte_valid is emitted; the next cycle shows sync_state = 0 and locked = 0. Separately, assert rst_n low mid-frame → all outputs 0 immediately.
